lmem_sweep_ctrl: RTL and testbench

- Sequencer owning both ports of one L-memory bank, which is a simple dual-port RAM with asynchronous read and a synchronous write on memclk.
- On start, performs one read-modify-write sweep over all MEMDEPTH entries, starting at a cyclic shift offset (QC-LDPC circulant). Each entry is read, streamed to the processing element (PE), and the PE result is written back PIPE_LAT cycles later.
- Between sweeps, arbitrates the write port for the host LLR-load requester.

---
 rtl/lmem_ctrl_pkg.sv | 15 +
 rtl/lmem_wb_delay.sv | 35 +++
 rtl/lmem_sweep_ctrl.sv | 144 ++++++++++++++
 tb/tb_lmem_sweep_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmem_ctrl_pkg.sv
// Shared definitions for the L-memory bank sequencer and its RAM instances.
package lmem_ctrl_pkg;

    localparam int LMEM_W     = 6;   // LLR word width
    localparam int LMEM_AW    = 9;   // RAM address width
    localparam int LMEM_DEPTH = 16;  // entries per bank (circulant size Z)

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/lmem_wb_delay.sv
// Write-back delay line: carries {valid, addr} of each read through the PE latency.
module lmem_wb_delay #(
    parameter int PIPE_LAT = 2,
    parameter int AW       = 9
) (
    input  logic          memclk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    output logic          out_valid,
    output logic [AW-1:0] out_addr
);

    logic [PIPE_LAT-1:0]         vld_pipe;
    logic [PIPE_LAT-1:0][AW-1:0] addr_pipe;

    // Shift register; stage 0 takes the current read, last stage feeds the write port.
    always_ff @(posedge memclk) begin
        if (!rst) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else begin
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
            vld_pipe[0]  <= in_valid;
            addr_pipe[0] <= in_addr;
        end
    end

    assign out_valid = vld_pipe[PIPE_LAT-1];
    assign out_addr  = addr_pipe[PIPE_LAT-1];

endmodule

// File: rtl/lmem_sweep_ctrl.sv
// L-memory bank sequencer: one cyclically shifted read-modify-write sweep per start,
// host write-port access between sweeps.
module lmem_sweep_ctrl
    import lmem_ctrl_pkg::*;
#(
    parameter int W            = LMEM_W,
    parameter int ADDRESSWIDTH = LMEM_AW,
    parameter int MEMDEPTH     = LMEM_DEPTH,
    parameter int PIPE_LAT     = 2
) (
    input  logic                    memclk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDRESSWIDTH-1:0] shift,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err,
    output logic [ADDRESSWIDTH-1:0] ram_ra,
    output logic                    ram_rd,
    input  logic [W-1:0]            ram_dout,
    output logic [W-1:0]            pe_din,
    output logic                    pe_valid,
    input  logic [W-1:0]            pe_result,
    output logic [ADDRESSWIDTH-1:0] ram_wa,
    output logic                    ram_wr,
    output logic [W-1:0]            ram_din,
    input  logic                    host_wr,
    input  logic [ADDRESSWIDTH-1:0] host_addr,
    input  logic [W-1:0]            host_data,
    output logic                    host_ack
);

    localparam int AW = ADDRESSWIDTH;
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    state_t         state, state_d;
    logic [AW-1:0]  cnt, shift_q;
    logic [DW-1:0]  dcnt;
    logic           cfg_err_q;
    logic [AW:0]    sum;
    logic [AW-1:0]  ra;
    logic           rd_int, ack_int, start_ok, start_bad, shift_ok;
    logic           wb_vld;
    logic [AW-1:0]  wb_addr;

    assign shift_ok  = ({1'b0, shift} < (AW+1)'(MEMDEPTH));
    assign start_ok  = (state == S_IDLE) & start & shift_ok;
    assign start_bad = (state == S_IDLE) & start & ~shift_ok;
    assign rd_int    = (state == S_SWEEP);
    // Start takes priority over a host write in the same idle cycle.
    assign ack_int   = host_wr & (state == S_IDLE) & ~start;

    // Read address: (shift_q + cnt) mod MEMDEPTH; both operands < MEMDEPTH so one subtract suffices.
    always_comb begin
        sum = {1'b0, shift_q} + {1'b0, cnt};
        ra  = (sum >= (AW+1)'(MEMDEPTH)) ? (sum[AW-1:0] - AW'(MEMDEPTH)) : sum[AW-1:0];
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (start_ok) state_d = S_SWEEP;
            S_SWEEP: if (cnt == AW'(MEMDEPTH - 1)) state_d = S_DRAIN;
            S_DRAIN: if (dcnt == DW'(PIPE_LAT - 1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge memclk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_d;
    end

    // Sweep/drain counters, latched shift and the registered config-error pulse.
    always_ff @(posedge memclk) begin
        if (!rst) begin
            cnt       <= '0;
            dcnt      <= '0;
            shift_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= start_bad;
            if (start_ok) begin
                shift_q <= shift;
                cnt     <= '0;
            end else if (state == S_SWEEP) begin
                cnt <= cnt + 1'b1;
            end
            if (state == S_SWEEP)      dcnt <= '0;
            else if (state == S_DRAIN) dcnt <= dcnt + 1'b1;
        end
    end

    lmem_wb_delay #(
        .PIPE_LAT (PIPE_LAT),
        .AW       (AW)
    ) u_wb_delay (
        .memclk    (memclk),
        .rst       (rst),
        .in_valid  (rd_int),
        .in_addr   (ra),
        .out_valid (wb_vld),
        .out_addr  (wb_addr)
    );

    // Output drive; everything is held at zero while reset is asserted.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        cfg_err  = 1'b0;
        ram_rd   = 1'b0;
        ram_ra   = '0;
        pe_din   = '0;
        pe_valid = 1'b0;
        ram_wr   = 1'b0;
        ram_wa   = '0;
        ram_din  = '0;
        host_ack = 1'b0;
        if (rst) begin
            busy     = (state != S_IDLE);
            done     = (state == S_DONE);
            cfg_err  = cfg_err_q;
            ram_rd   = rd_int;
            ram_ra   = rd_int ? ra : '0;
            pe_din   = ram_dout;
            pe_valid = rd_int;
            host_ack = ack_int;
            // Delayed write-back and host access never overlap: the line is empty in IDLE.
            if (wb_vld) begin
                ram_wr  = 1'b1;
                ram_wa  = wb_addr;
                ram_din = pe_result;
            end else if (ack_int) begin
                ram_wr  = 1'b1;
                ram_wa  = host_addr;
                ram_din = host_data;
            end
        end
    end

endmodule

// File: tb/tb_lmem_sweep_ctrl.sv
// Directed bench for lmem_sweep_ctrl with a behavioural RAM and a +1 PE of latency 2.
module tb_lmem_sweep_ctrl;

    localparam int W  = 6;
    localparam int AW = 9;
    localparam int MD = 16;
    localparam int PL = 2;

    logic          memclk = 1'b0;
    logic          rst, start, host_wr;
    logic [AW-1:0] shift, host_addr;
    logic [W-1:0]  host_data;
    logic          busy, done, cfg_err, ram_rd, pe_valid, ram_wr, host_ack;
    logic [AW-1:0] ram_ra, ram_wa;
    logic [W-1:0]  ram_dout, pe_din, pe_result, ram_din;

    logic [W-1:0]  mem [0:511];
    logic [W-1:0]  p1, p2;
    logic [W-1:0]  exp_mem [0:MD-1];
    logic [W-1:0]  pre [0:MD-1];
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 memclk = ~memclk;

    lmem_sweep_ctrl #(.W(W), .ADDRESSWIDTH(AW), .MEMDEPTH(MD), .PIPE_LAT(PL)) dut (
        .memclk(memclk), .rst(rst), .start(start), .shift(shift),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .ram_ra(ram_ra), .ram_rd(ram_rd), .ram_dout(ram_dout),
        .pe_din(pe_din), .pe_valid(pe_valid), .pe_result(pe_result),
        .ram_wa(ram_wa), .ram_wr(ram_wr), .ram_din(ram_din),
        .host_wr(host_wr), .host_addr(host_addr), .host_data(host_data),
        .host_ack(host_ack)
    );

    // RAM: async read, sync write; PE: +1 with two register stages.
    assign ram_dout  = mem[ram_ra];
    assign pe_result = p2;
    always @(posedge memclk) begin
        if (ram_wr) mem[ram_wa] <= ram_din;
        p1 <= pe_din + 6'd1;
        p2 <= p1;
    end

    task automatic step();
        @(posedge memclk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; shift = '0;
        host_wr = 1'b1; host_addr = 9'd3; host_data = 6'd7;
        #1;
        n_checks++;
        if ({busy, done, cfg_err, ram_rd, ram_wr, host_ack, pe_valid} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b want=0000000", {busy, done, cfg_err, ram_rd, ram_wr, host_ack, pe_valid});
        end
        n_checks++;
        if (ram_ra !== 9'd0 || ram_wa !== 9'd0 || ram_din !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_bus got ra=%0d wa=%0d din=%0d want 0", ram_ra, ram_wa, ram_din);
        end
        step(); step();
        host_wr = 1'b0; rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, cfg_err, ram_rd, ram_wr} !== 5'd0) begin
            n_fail++;
            $display("FAIL post_reset got=%b want=00000", {busy, done, cfg_err, ram_rd, ram_wr});
        end
    endtask

    task automatic test_host_load();
        for (int a = 0; a < MD; a++) begin
            host_wr = 1'b1; host_addr = 9'(a); host_data = 6'(a);
            #1;
            n_checks++;
            if (host_ack !== 1'b1 || ram_wr !== 1'b1 || ram_wa !== 9'(a) || ram_din !== 6'(a)) begin
                n_fail++;
                $display("FAIL host_load a=%0d got ack=%b wr=%b wa=%0d din=%0d want 1 1 %0d %0d",
                         a, host_ack, ram_wr, ram_wa, ram_din, a, a);
            end
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL host_load_busy a=%0d got=%b want=0", a, busy);
            end
            exp_mem[a] = 6'(a);
            step();
        end
        host_wr = 1'b0;
        step();
        for (int i = 0; i < MD; i++) begin
            n_checks++;
            if (mem[i] !== 6'(i)) begin
                n_fail++;
                $display("FAIL host_load_mem[%0d] got=%0d want=%0d", i, mem[i], i);
            end
        end
    endtask

    // One full sweep from IDLE with the given shift; returns in cycle 20, IDLE.
    task automatic test_sweep(input int s);
        logic [W-1:0] ev;
        int ra_e, wa_e;
        bit rd_e, wr_e;
        for (int i = 0; i < MD; i++) pre[i] = exp_mem[i];
        start = 1'b1; shift = 9'(s);
        step();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            rd_e = (c <= MD);
            ra_e = rd_e ? (s + c - 1) % MD : 0;
            wr_e = (c >= 1 + PL) && (c <= MD + PL);
            wa_e = (s + c - 1 - PL + MD) % MD;
            n_checks++;
            if (ram_rd !== rd_e || pe_valid !== rd_e || ram_ra !== 9'(ra_e)) begin
                n_fail++;
                $display("FAIL sweep_rd s=%0d c=%0d got rd=%b v=%b ra=%0d want %b %b %0d",
                         s, c, ram_rd, pe_valid, ram_ra, rd_e, rd_e, ra_e);
            end
            if (rd_e) begin
                n_checks++;
                if (pe_din !== pre[ra_e]) begin
                    n_fail++;
                    $display("FAIL sweep_pe_din s=%0d c=%0d got=%0d want=%0d", s, c, pe_din, pre[ra_e]);
                end
            end
            n_checks++;
            if (ram_wr !== wr_e) begin
                n_fail++;
                $display("FAIL sweep_wr s=%0d c=%0d got=%b want=%b", s, c, ram_wr, wr_e);
            end
            if (wr_e) begin
                ev = pre[wa_e] + 6'd1;
                n_checks++;
                if (ram_wa !== 9'(wa_e) || ram_din !== ev) begin
                    n_fail++;
                    $display("FAIL sweep_wb s=%0d c=%0d got wa=%0d din=%0d want %0d %0d",
                             s, c, ram_wa, ram_din, wa_e, ev);
                end
            end
            n_checks++;
            if (done !== (c == MD + PL + 1) || busy !== (c <= MD + PL + 1)) begin
                n_fail++;
                $display("FAIL sweep_status s=%0d c=%0d got done=%b busy=%b want %b %b",
                         s, c, done, busy, c == MD + PL + 1, c <= MD + PL + 1);
            end
            if (c < 20) step();
        end
        for (int i = 0; i < MD; i++) exp_mem[i] = pre[i] + 6'd1;
    endtask

    task automatic test_unshifted_sweep();
        test_sweep(0);
        for (int i = 0; i < MD; i++) begin
            n_checks++;
            if (mem[i] !== 6'(i + 1)) begin
                n_fail++;
                $display("FAIL unshifted_mem[%0d] got=%0d want=%0d", i, mem[i], i + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        test_sweep(0);
        for (int i = 0; i < MD; i++) begin
            n_checks++;
            if (mem[i] !== 6'(i + 2)) begin
                n_fail++;
                $display("FAIL b2b_mem[%0d] got=%0d want=%0d", i, mem[i], i + 2);
            end
        end
    endtask

    task automatic test_shifted_wrap();
        test_sweep(13);
        for (int i = 0; i < MD; i++) begin
            n_checks++;
            if (mem[i] !== 6'(i + 3)) begin
                n_fail++;
                $display("FAIL shifted_mem[%0d] got=%0d want=%0d", i, mem[i], i + 3);
            end
        end
    endtask

    task automatic test_cfg_err();
        step();
        start = 1'b1; shift = 9'd16;
        #1;
        n_checks++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_early got=%b want=0", cfg_err);
        end
        step();
        start = 1'b0;
        n_checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || ram_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_pulse got err=%b busy=%b rd=%b want 1 0 0", cfg_err, busy, ram_rd);
        end
        step();
        n_checks++;
        if (cfg_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_clear got err=%b busy=%b want 0 0", cfg_err, busy);
        end
    endtask

    task automatic test_arbitration();
        host_wr = 1'b1; host_addr = 9'd5; host_data = 6'd40;
        start = 1'b1; shift = 9'd0;
        #1;
        n_checks++;
        if (host_ack !== 1'b0 || ram_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_ack got ack=%b wr=%b want 0 0", host_ack, ram_wr);
        end
        step();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            n_checks++;
            if (host_ack !== (c == 20) || busy !== (c <= 19)) begin
                n_fail++;
                $display("FAIL arb c=%0d got ack=%b busy=%b want %b %b", c, host_ack, busy, c == 20, c <= 19);
            end
            if (c == 20) begin
                n_checks++;
                if (ram_wr !== 1'b1 || ram_wa !== 9'd5 || ram_din !== 6'd40) begin
                    n_fail++;
                    $display("FAIL arb_host_wr got wr=%b wa=%0d din=%0d want 1 5 40", ram_wr, ram_wa, ram_din);
                end
            end
            if (c < 20) step();
        end
        step();
        host_wr = 1'b0;
        for (int i = 0; i < MD; i++) exp_mem[i] = 6'(i + 4);
        exp_mem[5] = 6'd40;
        for (int i = 0; i < MD; i++) begin
            n_checks++;
            if (mem[i] !== exp_mem[i]) begin
                n_fail++;
                $display("FAIL arb_mem[%0d] got=%0d want=%0d", i, mem[i], exp_mem[i]);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        start = 1'b1; shift = 9'd0;
        step();
        start = 1'b0;
        for (int c = 1; c < 8; c++) step();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({ram_rd, ram_wr, busy} !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_reset_drop got rd,wr,busy=%b want 000", {ram_rd, ram_wr, busy});
        end
        step();
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || ram_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_idle got busy=%b rd=%b want 0 0", busy, ram_rd);
        end
        for (int c = 0; c < 22; c++) begin
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_nodone c=%0d got done=%b busy=%b want 0 0", c, done, busy);
            end
            step();
        end
        for (int i = 0; i < 5; i++) exp_mem[i] = exp_mem[i] + 6'd1;
        for (int i = 0; i < MD; i++) begin
            n_checks++;
            if (mem[i] !== exp_mem[i]) begin
                n_fail++;
                $display("FAIL mid_reset_mem[%0d] got=%0d want=%0d", i, mem[i], exp_mem[i]);
            end
        end
        test_sweep(0);
        for (int i = 0; i < MD; i++) begin
            n_checks++;
            if (mem[i] !== exp_mem[i]) begin
                n_fail++;
                $display("FAIL resweep_mem[%0d] got=%0d want=%0d", i, mem[i], exp_mem[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_host_load();
        test_unshifted_sweep();
        test_back_to_back();
        test_shifted_wrap();
        test_cfg_err();
        test_arbitration();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
